// File: rtl/fpga_rx_controller_if.sv
// fpga_rx_controller_if: serial line, shift-register, consumer handshake and status signals of the receive controller; master = controller, slave = environment
interface fpga_rx_controller_if;
  logic       rx_line;
  logic [7:0] sr_data;
  logic       sr_serial;
  logic       sr_shift;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       frame_err;
  logic       overrun;
  logic       clear_err;
  logic       busy;
  modport master (
    input  rx_line, sr_data, rx_ready, clear_err,
    output sr_serial, sr_shift, rx_data, rx_valid, frame_err, overrun, busy
  );
  modport slave (
    output rx_line, sr_data, rx_ready, clear_err,
    input  sr_serial, sr_shift, rx_data, rx_valid, frame_err, overrun, busy
  );
endinterface

// File: rtl/fpga_rx_controller.sv
// fpga_rx_controller: serial receive sequencer feeding an external SIPO shift register and a valid/ready consumer; ports clock, reset (async active-low), bus (rx_line, sr_data/sr_serial/sr_shift, rx_data/rx_valid/rx_ready, frame_err, overrun, clear_err, busy); define FPGA_RX_PARITY_EN for an even-parity bit
module fpga_rx_controller #(
  parameter int CLKS_PER_BIT = 16,
  parameter int SYNC_STAGES  = 2
) (
  input logic                  clock,
  input logic                  reset,
  fpga_rx_controller_if.master bus
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  typedef enum logic [2:0] {
    IDLE, START, DATA, STOP, BREAK
`ifdef FPGA_RX_PARITY_EN
    , PARITY
`endif
  } state_t;
  state_t state, next_state;
  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0] cnt;
  logic [2:0] bit_cnt;
  logic line, half_tick, bit_tick, stop_tick, good, load, err_set;
  assign line = sync_q[SYNC_STAGES-1];
`ifdef FPGA_RX_PARITY_EN
  logic par_acc, par_bad, par_tick, par_err;
  assign par_err = par_tick & (line ^ par_acc);
  assign good    = stop_tick & line & ~par_bad;
  assign err_set = (stop_tick & ~line) | par_err;
`else
  assign good    = stop_tick & line;
  assign err_set = stop_tick & ~line;
`endif
  assign load = good & (~bus.rx_valid | bus.rx_ready);
  always_ff @(posedge clock or negedge reset)
    if (!reset) state <= IDLE;
    else state <= next_state;
  always_comb begin
    next_state = state;
    case (state)
      IDLE:   next_state = line ? IDLE : START;
      START:  next_state = (cnt == HALF) ? (line ? IDLE : DATA) : START;
`ifdef FPGA_RX_PARITY_EN
      DATA:   next_state = (cnt == LAST && bit_cnt == 3'd7) ? PARITY : DATA;
      PARITY: next_state = (cnt == LAST) ? STOP : PARITY;
`else
      DATA:   next_state = (cnt == LAST && bit_cnt == 3'd7) ? STOP : DATA;
`endif
      STOP:   next_state = (cnt == LAST) ? (line ? IDLE : BREAK) : STOP;
      BREAK:  next_state = line ? IDLE : BREAK;
      default: next_state = IDLE;
    endcase
  end
  always_comb begin
    half_tick = state == START && cnt == HALF;
    bit_tick  = state == DATA && cnt == LAST;
    stop_tick = state == STOP && cnt == LAST;
`ifdef FPGA_RX_PARITY_EN
    par_tick  = state == PARITY && cnt == LAST;
`endif
    bus.busy  = state != IDLE;
  end
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      sync_q        <= '1;
      cnt           <= '0;
      bit_cnt       <= '0;
      bus.sr_serial <= 1'b0;
      bus.sr_shift  <= 1'b0;
      bus.rx_data   <= '0;
      bus.rx_valid  <= 1'b0;
      bus.frame_err <= 1'b0;
      bus.overrun   <= 1'b0;
`ifdef FPGA_RX_PARITY_EN
      par_acc       <= 1'b0;
      par_bad       <= 1'b0;
`endif
    end else begin
      sync_q        <= {sync_q[SYNC_STAGES-2:0], bus.rx_line};
      cnt           <= (state != next_state || cnt == LAST) ? '0 : cnt + 1'b1;
      bit_cnt       <= half_tick ? '0 : bit_tick ? bit_cnt + 3'd1 : bit_cnt;
      bus.sr_serial <= bit_tick ? line : bus.sr_serial;
      bus.sr_shift  <= bit_tick;
      bus.rx_data   <= load ? bus.sr_data : bus.rx_data;
      bus.rx_valid  <= load | (bus.rx_valid & ~bus.rx_ready);
      bus.overrun   <= (good & bus.rx_valid & ~bus.rx_ready) | (bus.overrun & ~bus.clear_err);
      bus.frame_err <= err_set | (bus.frame_err & ~bus.clear_err);
`ifdef FPGA_RX_PARITY_EN
      par_acc       <= half_tick ? 1'b0 : bit_tick ? par_acc ^ line : par_acc;
      par_bad       <= half_tick ? 1'b0 : par_err ? 1'b1 : par_bad;
`endif
    end
endmodule

// File: tb/tb_fpga_rx_controller.sv
// tb_fpga_rx_controller: scoreboard bench for fpga_rx_controller with a behavioural SIPO shift register
module tb_fpga_rx_controller;
  localparam int C = 4;
  localparam int S = 2;
  logic clock = 1'b0;
  logic reset = 1'b0;
  logic [7:0] sr_q = '0;
  logic busy_seen = 1'b0;
  int checks = 0, errors = 0, shifts = 0, extra_shifts = 0, extra_bytes = 0, valid_cycles = 0;
  logic bit_q[$];
  logic [7:0] byte_q[$];
  fpga_rx_controller_if bus();
  fpga_rx_controller #(.CLKS_PER_BIT(C), .SYNC_STAGES(S)) dut (.clock(clock), .reset(reset), .bus(bus));
  always #5 clock = ~clock;
  assign bus.sr_data = sr_q;
  always @(posedge clock) if (bus.sr_shift) sr_q <= {bus.sr_serial, sr_q[7:1]};
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  always @(negedge clock) begin
    #1;
    if (bus.busy) busy_seen = 1'b1;
    if (bus.rx_valid) valid_cycles++;
    if (bus.sr_shift) begin
      shifts++;
      if (bit_q.size() == 0) extra_shifts++;
      else check("shift_bit", 32'(bus.sr_serial), 32'(bit_q.pop_front()));
    end
    if (bus.rx_valid && bus.rx_ready) begin
      if (byte_q.size() == 0) extra_bytes++;
      else check("rx_byte", 32'(bus.rx_data), 32'(byte_q.pop_front()));
    end
  end
  task automatic send_frame(input logic [7:0] b, input logic stop, input logic push, input logic par_flip);
    bus.rx_line = 1'b0;
    repeat (C) @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      bus.rx_line = b[i];
      bit_q.push_back(b[i]);
      repeat (C) @(negedge clock);
    end
`ifdef FPGA_RX_PARITY_EN
    bus.rx_line = ^b ^ par_flip;
    repeat (C) @(negedge clock);
`endif
    bus.rx_line = stop;
    repeat (C) @(negedge clock);
    bus.rx_line = 1'b1;
    if (push && !par_flip) byte_q.push_back(b);
  endtask
  initial begin
    bus.rx_line = 1'b1;
    bus.rx_ready = 1'b1;
    bus.clear_err = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_sr_serial", 32'(bus.sr_serial), 0);
    check("rst_sr_shift", 32'(bus.sr_shift), 0);
    check("rst_rx_data", 32'(bus.rx_data), 0);
    check("rst_rx_valid", 32'(bus.rx_valid), 0);
    check("rst_frame_err", 32'(bus.frame_err), 0);
    check("rst_overrun", 32'(bus.overrun), 0);
    check("rst_busy", 32'(bus.busy), 0);
    reset = 1'b1;
    repeat (100) @(negedge clock);
    check("idle_shifts", shifts, 0);
    check("idle_busy", 32'(bus.busy), 0);
    check("idle_valid", 32'(bus.rx_valid), 0);
    shifts = 0; valid_cycles = 0;
    send_frame(8'hA5, 1'b1, 1'b1, 1'b0);
    repeat (4) @(negedge clock);
    check("a5_shifts", shifts, 8);
    check("a5_valid_cycles", valid_cycles, 1);
    check("a5_rx_data", 32'(bus.rx_data), 'hA5);
    check("a5_frame_err", 32'(bus.frame_err), 0);
    shifts = 0; busy_seen = 1'b0;
    bus.rx_line = 1'b0;
    @(negedge clock);
    bus.rx_line = 1'b1;
    repeat (C / 2 + S) @(negedge clock);
    check("glitch_busy_seen", 32'(busy_seen), 1);
    check("glitch_busy_end", 32'(bus.busy), 0);
    check("glitch_shifts", shifts, 0);
    shifts = 0;
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
    bus.rx_line = 1'b0;
    repeat (40) @(negedge clock);
    check("brk_frame_err", 32'(bus.frame_err), 1);
    check("brk_valid", 32'(bus.rx_valid), 0);
    check("brk_busy", 32'(bus.busy), 1);
    check("brk_shifts", shifts, 8);
    check("brk_rx_data", 32'(bus.rx_data), 'hA5);
    bus.rx_line = 1'b1;
    repeat (C) @(negedge clock);
    check("brk_idle", 32'(bus.busy), 0);
    bus.clear_err = 1'b1;
    @(negedge clock);
    bus.clear_err = 1'b0;
    check("brk_cleared", 32'(bus.frame_err), 0);
    bus.rx_ready = 1'b0;
    send_frame(8'h11, 1'b1, 1'b1, 1'b0);
    repeat (2) @(negedge clock);
    send_frame(8'h22, 1'b1, 1'b0, 1'b0);
    repeat (4) @(negedge clock);
    check("ovr_valid", 32'(bus.rx_valid), 1);
    check("ovr_rx_data", 32'(bus.rx_data), 'h11);
    check("ovr_flag", 32'(bus.overrun), 1);
    check("ovr_frame_err", 32'(bus.frame_err), 0);
    bus.rx_ready = 1'b1;
    @(negedge clock);
    check("ovr_valid_drop", 32'(bus.rx_valid), 0);
    bus.clear_err = 1'b1;
    @(negedge clock);
    bus.clear_err = 1'b0;
    check("ovr_cleared", 32'(bus.overrun), 0);
    shifts = 0;
    bus.rx_line = 1'b0;
    repeat (C) @(negedge clock);
    for (int i = 0; i < 4; i++) begin
      bus.rx_line = 1'b1;
      bit_q.push_back(1'b1);
      repeat (C) @(negedge clock);
    end
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (3) @(negedge clock);
    check("abort_busy", 32'(bus.busy), 0);
    check("abort_sr_serial", 32'(bus.sr_serial), 0);
    check("abort_rx_data", 32'(bus.rx_data), 0);
    reset = 1'b1;
    repeat (10) @(negedge clock);
    check("abort_shifts", shifts, 4);
`ifdef FPGA_RX_PARITY_EN
    send_frame(8'h0F, 1'b1, 1'b1, 1'b1);
    repeat (4) @(negedge clock);
    check("par_frame_err", 32'(bus.frame_err), 1);
    check("par_valid", 32'(bus.rx_valid), 0);
    check("par_rx_data", 32'(bus.rx_data), 0);
`else
    send_frame(8'h0F, 1'b1, 1'b1, 1'b0);
    repeat (4) @(negedge clock);
    check("post_rx_data", 32'(bus.rx_data), 'h0F);
    check("post_frame_err", 32'(bus.frame_err), 0);
`endif
    check("post_shifts", shifts, 12);
    check("bit_q_empty", bit_q.size(), 0);
    check("byte_q_empty", byte_q.size(), 0);
    check("extra_shifts", extra_shifts, 0);
    check("extra_bytes", extra_bytes, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fpga_rx_controller.md
Name: fpga_rx_controller

Overview:
- Receive-side sequencer for the FPGA-to-FPGA serial link.
- Watches the incoming serial line, finds the start bit and samples each data bit at mid-bit.
- Drives the external 8-bit serial-in/parallel-out shift register through its serial input and shift strobe.
- Captures the register's parallel output after a valid stop bit and hands the byte to the consumer over a valid/ready handshake.

Parameters:
- CLKS_PER_BIT, 16: system clocks per serial bit; must be ≥4 and even.
- SYNC_STAGES, 2: synchroniser flops on rx_line; must be ≥2.

Ports:
- clock  input  1  system clock; all logic on rising edge.
- reset  input  1  system reset; asynchronous, active-low.
- rx_line  input  1  serial line; idles high.
- sr_data  input  8  parallel output of the external shift register.
- sr_serial  output  1  sampled bit, wired to the shift register's serial input.
- sr_shift  output  1  one-cycle shift strobe to the shift register.
- rx_data  output  8  received byte.
- rx_valid  output  1  rx_data holds an unconsumed byte.
- rx_ready  input  1  consumer accepts the byte.
- frame_err  output  1  sticky: stop bit (or parity) failed.
- overrun  output  1  sticky: a good frame arrived while rx_valid was already high.
- clear_err  input  1  clears frame_err and overrun.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE; counters go to 0.
  - Synchroniser flops go to 1, so no false start on release.
  - All outputs go to 0, including sr_serial, sr_shift, rx_data, rx_valid, frame_err, overrun and busy.
  - A reset during a frame abandons it; no shift strobe follows.
- rx_line is passed through SYNC_STAGES flops; "line" below means the synchronised value.
- States: IDLE, START, DATA, STOP, (PARITY), BREAK.
- IDLE:
  - line=0 → START, clock counter=0.
- START:
  - At counter=CLKS_PER_BIT/2−1, sample the line.
  - If 1 (glitch) → IDLE, with no error.
  - If 0 → DATA, counter=0, bit count=0.
- DATA:
  - At counter=CLKS_PER_BIT−1, sr_serial takes the sampled line value.
  - sr_shift pulses high for exactly the following cycle, so sr_serial is stable during the strobe.
  - Bit count increments; counter returns to 0.
  - After the 8th strobe → STOP, or → PARITY when the optional feature is compiled in.
  - sr_serial holds its last value between samples.
- Bits are presented in line order, first received bit first. Bit significance is set by the shift register wiring; the bench models it as shifting in at bit 7 toward bit 0 (LSB-first line).
- STOP, at counter=CLKS_PER_BIT−1:
  - Line=1, rx_valid=0: rx_data←sr_data and rx_valid←1 in the same cycle; → IDLE.
  - Line=1, rx_valid=1: byte dropped, rx_data unchanged, overrun←1; → IDLE.
  - Line=0: frame_err←1, byte dropped; → BREAK.
- BREAK:
  - Stays until line=1, then → IDLE. A held-low line never triggers a new frame.
- Handshake:
  - rx_valid stays high until a cycle with rx_valid&rx_ready; it clears on the next edge.
  - If the consume cycle coincides with a good stop-bit capture, the new byte loads and rx_valid stays 1; no overrun.
- clear_err=1 clears both sticky flags at the next edge. A flag-setting event in the same cycle wins.
- Latency: rx_valid rises (8+1)·CLKS_PER_BIT + CLKS_PER_BIT/2 + SYNC_STAGES clocks after the line falls at the start bit (+CLKS_PER_BIT with parity).

Optional Feature:
- Macro: FPGA_RX_PARITY_EN.
- Defined:
  - PARITY state between DATA and STOP samples one even-parity bit at counter=CLKS_PER_BIT−1.
  - The controller keeps an XOR of the 8 sampled bits. A parity mismatch sets frame_err and drops the byte, but the controller still waits for the stop bit before → IDLE. A bad stop bit still goes → BREAK.
  - No shift strobe is issued for the parity bit.
- Undefined: the PARITY state, the XOR tracking and the parity bit slot are absent; frame is start, 8 data bits, stop.

Test Plan:
- CLKS_PER_BIT=4, idle line, release reset → all outputs 0; no sr_shift for 100 clocks.
- Frame 0xA5 LSB-first with good stop, rx_ready=1 → exactly 8 sr_shift pulses carrying 1,0,1,0,0,1,0,1; rx_data=0xA5; rx_valid high one cycle; frame_err=0.
- Line low for 1 clock only (glitch) → returns to IDLE, no sr_shift, busy back to 0 within CLKS_PER_BIT/2+SYNC_STAGES+1 clocks.
- Frame 0x3C with stop bit 0, then line held low 40 clocks → frame_err=1, rx_valid=0, no new START until line high; clear_err → frame_err=0.
- rx_ready=0, frames 0x11 then 0x22 → rx_data=0x11, overrun=1; raise rx_ready → rx_valid drops next cycle.
- Reset asserted at 4th data bit of 0xFF, line kept high after release, then frame 0x0F → only 4 pre-reset strobes; rx_data=0x0F after second frame (FPGA_RX_PARITY_EN: 0x0F with parity bit 1 → frame_err=1, byte dropped).
